// File: rtl/state_coord_mapper_pkg.sv
// state_coord_mapper_pkg
// Shared definitions for the state/coordinate mapper slice: request opcode
// encodings, STEP action encodings, default mesh dimensions and a small
// helper used to size the coordinate fields.
package state_coord_mapper_pkg;

  // Request opcodes carried on in_op.
  typedef enum logic [1:0] {
    OP_COORD2IDX = 2'd0,
    OP_IDX2COORD = 2'd1,
    OP_STEP      = 2'd2,
    OP_RSVD      = 2'd3
  } op_e;

  // STEP move directions carried on in_action. The mesh origin (1,1) is
  // the north-west corner, so south increases y and east increases x.
  typedef enum logic [1:0] {
    ACT_EAST  = 2'd0,
    ACT_WEST  = 2'd1,
    ACT_SOUTH = 2'd2,
    ACT_NORTH = 2'd3
  } action_e;

  // Default mesh dimensions (columns x rows).
  localparam int DEF_MESH_W = 4;
  localparam int DEF_MESH_H = 4;

  // Larger of two integers; sizes a coordinate so it can hold either extent.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/state_coord_mapper_div.sv
// state_coord_div
// Iterative divide-by-constant used to split a 1-based linear state index
// into its 1-based (x, y) mesh coordinate. One subtraction of MESH_W is
// performed per cycle while the running remainder exceeds MESH_W, so no
// hardware divider or modulo operator is needed.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; aborts any division in flight
//   start     one-cycle pulse loading a new dividend
//   dividend  1-based linear index to split (must be 1..MESH_W*MESH_H)
//   done      high during the cycle in which x/y hold the final result
//   x         1-based column (final remainder)
//   y         1-based row (quotient + 1)
module state_coord_div #(
  parameter int MESH_W = 4,
  parameter int IDX_W  = 5,
  parameter int CRD_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] dividend,
  output logic             done,
  output logic [CRD_W-1:0] x,
  output logic [CRD_W-1:0] y
);

  localparam logic [IDX_W-1:0] W_IDX = IDX_W'(MESH_W);

  logic             busy_q;
  logic [IDX_W-1:0] rem_q;
  logic [CRD_W-1:0] quo_q;

  // Remainder starts at the index itself and the row at 1; once the
  // remainder is no larger than one row width it is directly the column.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      rem_q  <= dividend;
      quo_q  <= CRD_W'(1);
    end else if (busy_q) begin
      if (rem_q > W_IDX) begin
        rem_q <= rem_q - W_IDX;
        quo_q <= quo_q + CRD_W'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  // The final remainder is at most MESH_W, so it always fits a coordinate.
  assign done = busy_q && (rem_q <= W_IDX);
  assign x    = rem_q[CRD_W-1:0];
  assign y    = quo_q;

endmodule

// File: rtl/state_coord_mapper.sv
// state_coord_mapper
// Converts between 1-based mesh coordinates (x, y) and a 1-based linear
// state index idx = (y-1)*MESH_W + x, and optionally performs one STEP move
// on the mesh with edge (wall) detection.
//
// Optional feature macro: STATE_MAP_STEP_EN
//   defined   -> op=2 (STEP) applies in_action and reports out_wall
//   undefined -> STEP logic absent, op=2 reported as illegal, out_wall=0
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (ready only while idle)
//   in_op               0=COORD2IDX, 1=IDX2COORD, 2=STEP, 3=reserved
//   in_x, in_y          1-based coordinate operands (COORD2IDX)
//   in_idx              1-based linear operand (IDX2COORD, STEP)
//   in_action           STEP direction: 0=east 1=west 2=south 3=north
//   out_valid/out_ready result handshake; outputs held until accepted
//   out_idx, out_x/y    result state in both forms (0 on error)
//   out_err             operand out of range or illegal op
//   out_wall            STEP blocked by the mesh edge
module state_coord_mapper
  import state_coord_mapper_pkg::*;
#(
  parameter  int MESH_W = DEF_MESH_W,
  parameter  int MESH_H = DEF_MESH_H,
  localparam int IDX_W  = $clog2(MESH_W * MESH_H + 1),
  localparam int CRD_W  = $clog2(max2(MESH_W, MESH_H) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [CRD_W-1:0] in_x,
  input  logic [CRD_W-1:0] in_y,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [1:0]       in_action,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CRD_W-1:0] out_x,
  output logic [CRD_W-1:0] out_y,
  output logic             out_err,
  output logic             out_wall
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] W_IDX = IDX_W'(MESH_W);
  localparam logic [IDX_W-1:0] N_IDX = IDX_W'(MESH_W * MESH_H);
  localparam logic [CRD_W-1:0] W_CRD = CRD_W'(MESH_W);
  localparam logic [CRD_W-1:0] H_CRD = CRD_W'(MESH_H);

  logic [1:0]       state_q;
  logic [1:0]       op_q;
  logic [CRD_W-1:0] x_q;
  logic [CRD_W-1:0] y_q;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;

  logic [IDX_W-1:0] out_idx_q;
  logic [CRD_W-1:0] out_x_q;
  logic [CRD_W-1:0] out_y_q;
  logic             out_err_q;

  logic             accept;
  logic             op_illegal;
  logic             acc_err;
  logic             acc_div;

  logic             div_done;
  logic [CRD_W-1:0] div_x;
  logic [CRD_W-1:0] div_y;

  logic [IDX_W-1:0] c2i_idx;

  logic             calc_fin;
  logic [IDX_W-1:0] res_idx;
  logic [CRD_W-1:0] res_x;
  logic [CRD_W-1:0] res_y;
  logic             res_err;
  logic             res_wall;

`ifdef STATE_MAP_STEP_EN
  logic [1:0]       act_q;
  logic             out_wall_q;
  logic [IDX_W-1:0] step_idx;
  logic [CRD_W-1:0] step_x;
  logic [CRD_W-1:0] step_y;
  logic             step_wall;
`else
  logic             unused_action;
  assign unused_action = ^in_action;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_ready && in_valid;

  // Range check done on the raw request so an erroneous request never
  // starts the divider and always finishes after a single CALC cycle.
  always_comb begin
    op_illegal = 1'b0;
    acc_err    = 1'b0;
    acc_div    = 1'b0;
`ifdef STATE_MAP_STEP_EN
    op_illegal = (in_op == OP_RSVD);
`else
    op_illegal = (in_op == OP_RSVD) || (in_op == OP_STEP);
`endif
    case (in_op)
      OP_COORD2IDX: acc_err = (in_x == '0) || (in_x > W_CRD) ||
                              (in_y == '0) || (in_y > H_CRD);
      OP_IDX2COORD,
      OP_STEP:      acc_err = (in_idx == '0) || (in_idx > N_IDX);
      default:      acc_err = 1'b0;
    endcase
    acc_err = acc_err || op_illegal;
    acc_div = !acc_err && ((in_op == OP_IDX2COORD) || (in_op == OP_STEP));
  end

  state_coord_div #(
    .MESH_W (MESH_W),
    .IDX_W  (IDX_W),
    .CRD_W  (CRD_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && acc_div),
    .dividend (in_idx),
    .done     (div_done),
    .x        (div_x),
    .y        (div_y)
  );

  // Row offset uses a multiply by the constant MESH_W, which synthesis
  // reduces to shifts/adds.
  assign c2i_idx = (IDX_W'(y_q) - IDX_W'(1)) * W_IDX + IDX_W'(x_q);

`ifdef STATE_MAP_STEP_EN
  // Apply the move to the recovered coordinate. Moving one column changes
  // the index by 1, moving one row changes it by MESH_W; a move off the
  // mesh leaves the state untouched and flags the wall instead.
  always_comb begin
    step_idx  = idx_q;
    step_x    = div_x;
    step_y    = div_y;
    step_wall = 1'b0;
    case (act_q)
      ACT_EAST: begin
        if (div_x == W_CRD) begin
          step_wall = 1'b1;
        end else begin
          step_x   = div_x + CRD_W'(1);
          step_idx = idx_q + IDX_W'(1);
        end
      end
      ACT_WEST: begin
        if (div_x == CRD_W'(1)) begin
          step_wall = 1'b1;
        end else begin
          step_x   = div_x - CRD_W'(1);
          step_idx = idx_q - IDX_W'(1);
        end
      end
      ACT_SOUTH: begin
        if (div_y == H_CRD) begin
          step_wall = 1'b1;
        end else begin
          step_y   = div_y + CRD_W'(1);
          step_idx = idx_q + W_IDX;
        end
      end
      default: begin
        if (div_y == CRD_W'(1)) begin
          step_wall = 1'b1;
        end else begin
          step_y   = div_y - CRD_W'(1);
          step_idx = idx_q - W_IDX;
        end
      end
    endcase
  end
`endif

  // Result selection for the CALC state. calc_fin marks the last CALC
  // cycle: immediately for errors and COORD2IDX, and on div_done for the
  // ops that need the coordinate recovered first.
  always_comb begin
    calc_fin = 1'b0;
    res_idx  = '0;
    res_x    = '0;
    res_y    = '0;
    res_err  = 1'b0;
    res_wall = 1'b0;
    if (err_q) begin
      calc_fin = 1'b1;
      res_err  = 1'b1;
    end else begin
      case (op_q)
        OP_COORD2IDX: begin
          calc_fin = 1'b1;
          res_idx  = c2i_idx;
          res_x    = x_q;
          res_y    = y_q;
        end
        OP_IDX2COORD: begin
          calc_fin = div_done;
          res_idx  = idx_q;
          res_x    = div_x;
          res_y    = div_y;
        end
`ifdef STATE_MAP_STEP_EN
        OP_STEP: begin
          calc_fin = div_done;
          res_idx  = step_idx;
          res_x    = step_x;
          res_y    = step_y;
          res_wall = step_wall;
        end
`endif
        default: begin
          calc_fin = 1'b1;
          res_err  = 1'b1;
        end
      endcase
    end
  end

  // Control FSM plus request/result registers. Results are captured on the
  // CALC->DONE edge and held through DONE until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      out_idx_q  <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      out_err_q  <= 1'b0;
`ifdef STATE_MAP_STEP_EN
      act_q      <= '0;
      out_wall_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            x_q     <= in_x;
            y_q     <= in_y;
            idx_q   <= in_idx;
            err_q   <= acc_err;
`ifdef STATE_MAP_STEP_EN
            act_q   <= in_action;
`endif
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (calc_fin) begin
            out_idx_q  <= res_idx;
            out_x_q    <= res_x;
            out_y_q    <= res_y;
            out_err_q  <= res_err;
`ifdef STATE_MAP_STEP_EN
            out_wall_q <= res_wall;
`endif
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_idx = out_idx_q;
  assign out_x   = out_x_q;
  assign out_y   = out_y_q;
  assign out_err = out_err_q;

`ifdef STATE_MAP_STEP_EN
  assign out_wall = out_wall_q;
`else
  assign out_wall = 1'b0;
  logic unused_res_wall;
  assign unused_res_wall = res_wall;
`endif

endmodule

// File: doc/state_coord_mapper.md
STATE_COORD_MAPPER -- requirements
Module: state_coord_mapper

Interface
REQ-001 Parameter MESH_W, default 4, mesh columns (x range 1..MESH_W).
REQ-002 Parameter MESH_H, default 4, mesh rows (y range 1..MESH_H).
REQ-003 Derived constants: IDX_W = clog2(MESH_W*MESH_H+1); CRD_W = clog2(max(MESH_W,MESH_H)+1).
REQ-004 Port clk  input  1  single clock, rising-edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  request present.
REQ-007 Port in_ready  output  1  block can accept a request.
REQ-008 Port in_op  input  2  0=COORD2IDX, 1=IDX2COORD, 2=STEP, 3=reserved.
REQ-009 Port in_x, in_y  input  CRD_W each  1-based coordinates (COORD2IDX).
REQ-010 Port in_idx  input  IDX_W  1-based linear state (IDX2COORD, STEP).
REQ-011 Port in_action  input  2  STEP move: 0=east x+1, 1=west x-1, 2=south y+1, 3=north y-1.
REQ-012 Port out_valid  output  1  result present.
REQ-013 Port out_ready  input  1  consumer accepts result.
REQ-014 Port out_idx  output  IDX_W; out_x, out_y  output  CRD_W each  result state in both forms.
REQ-015 Port out_err  output  1  request operand out of range or op illegal.
REQ-016 Port out_wall  output  1  STEP move blocked by mesh edge.

Function
REQ-017 Mapping: idx = (y-1)*MESH_W + x; x = ((idx-1) mod MESH_W)+1; y = ((idx-1) div MESH_W)+1.
REQ-018 FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-019 IDLE: in_valid=1 latches operands and goes to CALC on the same edge.
REQ-020 IDX2COORD/STEP: CALC divides by iterative subtraction, one subtraction of MESH_W per cycle, rem starting at idx, y starting at 1, while rem > MESH_W; no hardware divider or modulo operator.
REQ-021 COORD2IDX: CALC completes in one cycle; (y-1)*MESH_W computed with a constant multiply.
REQ-022 Latency: accept at edge k -> out_valid high after edge k+1+n, where n = (idx-1) div MESH_W for IDX2COORD/STEP and n = 0 otherwise; worst case MESH_H.
REQ-023 STEP: after the coordinate is recovered, apply in_action in the final CALC cycle; out_x/out_y/out_idx = new state.
REQ-024 STEP at edge (x=MESH_W east, x=1 west, y=MESH_H south, y=1 north): state unchanged, out_wall=1, out_err=0.
REQ-025 Range check at accept: idx outside 1..MESH_W*MESH_H, x outside 1..MESH_W, y outside 1..MESH_H, or op=3 -> n=0, out_err=1, out_idx/out_x/out_y=0.
REQ-026 out_idx, out_x and out_y are all valid for every non-error op; COORD2IDX echoes inputs on out_x/out_y.
REQ-027 DONE: out_valid=1 and outputs stable until out_valid&out_ready; on that edge go to IDLE; next accept no earlier than the following edge.
REQ-028 out_ready is ignored outside DONE; in_valid is ignored outside IDLE.

Reset
REQ-029 rst=1 at any edge, including mid-CALC or DONE, forces IDLE and drops the in-flight request without output.
REQ-030 Reset values: out_valid=0, out_err=0, out_wall=0, out_idx=0, out_x=0, out_y=0; in_ready=1 on the first cycle after reset.

Configuration
REQ-031 Macro STATE_MAP_STEP_EN defined: STEP op and out_wall behave per REQ-023/024.
REQ-032 Macro STATE_MAP_STEP_EN undefined: STEP logic absent; op=2 is treated as illegal (out_err=1); out_wall is tied to 0.

Structure
REQ-033 Shared package (noc define file): op encodings, action encodings, default MESH_W/MESH_H.
REQ-034 One sub-module state_coord_div (iterative subtract-divide by constant MESH_W, start/done handshake), instantiated once.

Verification (MESH_W=MESH_H=4)
REQ-035 COORD2IDX x=2,y=1 -> out_idx=2, out_valid after 2 edges, err=0.
REQ-036 IDX2COORD idx=16 -> x=4, y=4, out_valid after 5 edges; idx=5 -> x=1, y=2 after 3 edges.
REQ-037 STEP idx=4, action=east -> out_idx=4, wall=1; idx=6, action=north -> out_idx=2, x=2, y=1, wall=0.
REQ-038 IDX2COORD idx=0 and idx=17; COORD2IDX x=5 -> out_err=1, outputs 0, out_valid after 2 edges.
REQ-039 out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; rst asserted mid-CALC for idx=16 -> no out_valid, in_ready=1 on the next cycle.
REQ-040 Build without STATE_MAP_STEP_EN: STEP idx=6 -> out_err=1, out_wall=0.
